// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with a registered write command.
// Define REGFILE_ARB_CLEAR_EN to zero registers 1..2**R-1 after every reset.
module regfile_write_arbiter #(
  parameter int N = 32,
  parameter int R = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [R-1:0] req0_addr,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [R-1:0] req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         rf_write_en,
  output logic [R-1:0] rf_write_add,
  output logic [N-1:0] rf_write_data,
  output logic         busy,
  output logic         last_grant
);

  logic         last_grant_q, last_grant_d;
  logic         wr_en_q, wr_en_d;
  logic [R-1:0] wr_add_q, wr_add_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic         run;

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_e;
  state_e       state_q, state_d;
  logic [R-1:0] cnt_q, cnt_d;
  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif

  assign busy = ~run;

  // When both requesters are valid, the one that did not win last time goes.
  assign req0_ready = run & req0_valid & (~req1_valid | last_grant_q);
  assign req1_ready = run & req1_valid & (~req0_valid | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_add_d     = wr_add_q;
    wr_data_d    = wr_data_q;
`ifdef REGFILE_ARB_CLEAR_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
`endif
    if (req0_ready) begin
      last_grant_d = 1'b0;
      wr_en_d      = (req0_addr != '0);
      wr_add_d     = req0_addr;
      wr_data_d    = req0_data;
    end else if (req1_ready) begin
      last_grant_d = 1'b1;
      wr_en_d      = (req1_addr != '0);
      wr_add_d     = req1_addr;
      wr_data_d    = req1_data;
    end
`ifdef REGFILE_ARB_CLEAR_EN
    if (state_q == CLEAR) begin
      wr_en_d   = 1'b1;
      wr_add_d  = cnt_q;
      wr_data_d = '0;
      cnt_d     = cnt_q + R'(1);
      if (cnt_q == '1) state_d = RUN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_add_q     <= '0;
      wr_data_q    <= '0;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q      <= CLEAR;
      cnt_q        <= R'(1);
`endif
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_add_q     <= wr_add_d;
      wr_data_q    <= wr_data_d;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_add  = wr_add_q;
  assign rf_write_data = wr_data_q;
  assign last_grant    = last_grant_q;

endmodule
